// File: rtl/dc_tag_nbank.sv
// Banked, set-associative data-cache tag array with a two-stage lookup/write pipeline.
// S1 accesses the bank's row and resolves hit/victim; S2 is the registered ack, held while the consumer stalls.
module dc_tag_nbank #(
  parameter int TAG_BITS  = 18,
  parameter int SET_BITS  = 9,
  parameter int BANK_BITS = 1,
  parameter int WAYS      = 4,
  parameter int REQ_BITS  = 7,
  parameter int FORWARD   = 1,
  localparam int WB       = $clog2(WAYS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_retry,
  input  logic                 req_write,
  input  logic [REQ_BITS-1:0]  req_type,
  input  logic [SET_BITS-1:0]  req_set,
  input  logic [TAG_BITS-1:0]  req_tag,
  input  logic [WB-1:0]        req_way,
  input  logic [2:0]           req_state,
  output logic                 ack_valid,
  input  logic                 ack_retry,
  output logic                 ack_hit,
  output logic                 ack_miss,
  output logic [WB-1:0]        ack_way,
  output logic [2:0]           ack_state,
  output logic [BANK_BITS-1:0] ack_bank,
  output logic [REQ_BITS-1:0]  ack_req_type
);

  localparam int BANKS    = 1 << BANK_BITS;
  localparam int ROW_BITS = SET_BITS - BANK_BITS;
  localparam int ROWS     = 1 << ROW_BITS;

  logic                 s1_valid;
  logic                 s1_write;
  logic [REQ_BITS-1:0]  s1_type;
  logic [BANK_BITS-1:0] s1_bank;
  logic [ROW_BITS-1:0]  s1_row;
  logic [TAG_BITS-1:0]  s1_tag;
  logic [WB-1:0]        s1_way;
  logic [2:0]           s1_state;

  logic [2:0]          state_mem [BANKS][ROWS][WAYS];
  logic [TAG_BITS-1:0] tag_mem   [BANKS][ROWS][WAYS];
  logic [WB-1:0]       vptr      [BANKS];

  logic          stall;
  logic          advance;
  logic          accept;
  logic          hazard;
  logic          mem_we;
  logic          consume_miss;
  logic          victim_bump;
  logic [WB-1:0] victim;
  logic          lk_hit;
  logic [WB-1:0] lk_way;
  logic [2:0]    lk_state;

  assign stall        = ack_valid & ack_retry;
  assign advance      = ~stall;
  assign consume_miss = ack_valid & ~ack_retry & ack_miss;

  // The array write commits at the end of S1, so a lookup that reaches S1 one cycle
  // behind a write already reads the new entry; FORWARD=0 instead holds that lookup
  // at the input for the one cycle the write sits in S1.
  assign hazard = (FORWARD == 0) && req_valid && !req_write && s1_valid && s1_write &&
                  (req_set == {s1_row, s1_bank});

  assign req_retry = ~reset | stall | hazard;
  assign accept    = req_valid & ~req_retry;
  assign mem_we    = s1_valid & s1_write & advance;

  // A miss ack leaving S2 on the same edge that S1 advances must be reflected in the
  // victim S1 reports, otherwise back-to-back misses to one bank repeat a way.
  assign victim_bump = consume_miss && (ack_bank == s1_bank);
  assign victim      = vptr[s1_bank] + (victim_bump ? WB'(1) : WB'(0));

  always_comb begin
    lk_hit   = 1'b0;
    lk_way   = victim;
    lk_state = 3'd0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (state_mem[s1_bank][s1_row][w] != 3'd0 && tag_mem[s1_bank][s1_row][w] == s1_tag) begin
        lk_hit   = 1'b1;
        lk_way   = WB'(w);
        lk_state = state_mem[s1_bank][s1_row][w];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_write <= 1'b0;
      s1_type  <= '0;
      s1_bank  <= '0;
      s1_row   <= '0;
      s1_tag   <= '0;
      s1_way   <= '0;
      s1_state <= '0;
    end else if (advance) begin
      s1_valid <= accept;
      if (accept) begin
        s1_write <= req_write;
        s1_type  <= req_type;
        s1_bank  <= req_set[BANK_BITS-1:0];
        s1_row   <= req_set[SET_BITS-1:BANK_BITS];
        s1_tag   <= req_tag;
        s1_way   <= req_way;
        s1_state <= req_state;
      end
    end
  end

  // Only the state field is cleared; stale tags are masked by state=0 in the compare.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < BANKS; b++)
        for (int r = 0; r < ROWS; r++)
          for (int w = 0; w < WAYS; w++)
            state_mem[b][r][w] <= 3'd0;
    end else if (mem_we) begin
      state_mem[s1_bank][s1_row][s1_way] <= s1_state;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) tag_mem[s1_bank][s1_row][s1_way] <= s1_tag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < BANKS; b++) vptr[b] <= '0;
    end else if (consume_miss) begin
      vptr[ack_bank] <= vptr[ack_bank] + WB'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_valid    <= 1'b0;
      ack_hit      <= 1'b0;
      ack_miss     <= 1'b0;
      ack_way      <= '0;
      ack_state    <= '0;
      ack_bank     <= '0;
      ack_req_type <= '0;
    end else if (advance) begin
      ack_valid <= s1_valid;
      if (s1_valid) begin
        ack_hit      <= s1_write | lk_hit;
        ack_miss     <= ~s1_write & ~lk_hit;
        ack_way      <= s1_write ? s1_way : lk_way;
        ack_state    <= s1_write ? s1_state : lk_state;
        ack_bank     <= s1_bank;
        ack_req_type <= s1_type;
      end else begin
        ack_hit  <= 1'b0;
        ack_miss <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dc_tag_nbank.sv
// Scoreboard bench for dc_tag_nbank: a set-indexed reference model predicts each ack at
// acceptance; a negedge monitor checks acks, latency, and stall hold behaviour.
module tb_dc_tag_nbank;

  localparam int FORWARD_P = 1;

  typedef struct {
    bit         hit;
    bit         miss;
    logic [1:0] way;
    logic [2:0] state;
    logic [0:0] bank;
    logic [6:0] rtype;
    int         acc_cycle;
    int         acc_stalls;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_retry;
  logic        req_write;
  logic [6:0]  req_type;
  logic [8:0]  req_set;
  logic [17:0] req_tag;
  logic [1:0]  req_way;
  logic [2:0]  req_state;
  logic        ack_valid;
  logic        ack_retry;
  logic        ack_hit;
  logic        ack_miss;
  logic [1:0]  ack_way;
  logic [2:0]  ack_state;
  logic [0:0]  ack_bank;
  logic [6:0]  ack_req_type;

  exp_t        exp_q[$];
  logic [17:0] m_tag [512][4];
  logic [2:0]  m_st  [512][4];
  int          miss_cnt [2];

  int          num_checks = 0;
  int          num_errors = 0;
  int          cycle = 0;
  int          stall_cnt = 0;
  bit          prev_stall = 0;
  logic [31:0] snap;
  logic [31:0] cur;
  bit          rand_ack = 0;
  bit          ack_force = 0;
  int          r;

  dc_tag_nbank #(
    .TAG_BITS(18), .SET_BITS(9), .BANK_BITS(1), .WAYS(4), .REQ_BITS(7), .FORWARD(FORWARD_P)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_retry(req_retry), .req_write(req_write),
    .req_type(req_type), .req_set(req_set), .req_tag(req_tag),
    .req_way(req_way), .req_state(req_state),
    .ack_valid(ack_valid), .ack_retry(ack_retry), .ack_hit(ack_hit), .ack_miss(ack_miss),
    .ack_way(ack_way), .ack_state(ack_state), .ack_bank(ack_bank), .ack_req_type(ack_req_type)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  always @(posedge clk) begin
    #1;
    ack_retry = rand_ack ? ($urandom_range(0, 3) == 0) : ack_force;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  function automatic void modelReset();
    for (int s = 0; s < 512; s++)
      for (int w = 0; w < 4; w++) m_st[s][w] = 3'd0;
    miss_cnt[0] = 0;
    miss_cnt[1] = 0;
  endfunction

  // Predicts the ack from set-level contents; misses take the bank's count of earlier misses mod 4.
  function automatic exp_t predict(input bit wr, input logic [8:0] set, input logic [17:0] tag,
                                   input logic [1:0] way, input logic [2:0] st, input logic [6:0] rt);
    exp_t e;
    int   s = int'(set);
    int   b = s % 2;
    e.hit = 0; e.miss = 0; e.way = 2'd0; e.state = 3'd0;
    if (wr) begin
      m_tag[s][way] = tag;
      m_st[s][way]  = st;
      e.hit = 1; e.way = way; e.state = st;
    end else begin
      for (int w = 0; w < 4; w++) begin
        if (!e.hit && m_st[s][w] != 3'd0 && m_tag[s][w] == tag) begin
          e.hit = 1; e.way = 2'(w); e.state = m_st[s][w];
        end
      end
      if (!e.hit) begin
        e.miss = 1;
        e.way  = 2'(miss_cnt[b] % 4);
        miss_cnt[b]++;
      end
    end
    e.bank  = 1'(b);
    e.rtype = rt;
    e.acc_cycle  = cycle;
    e.acc_stalls = stall_cnt;
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic applyStimulus(input bit wr, input logic [8:0] set, input logic [17:0] tag,
                               input logic [1:0] way, input logic [2:0] st, output int retries);
    retries   = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_set   = set;
    req_tag   = tag;
    req_way   = way;
    req_state = st;
    req_type  = 7'($urandom);
    forever begin
      @(negedge clk);
      if (!req_retry) begin
        exp_q.push_back(predict(wr, set, tag, way, st, req_type));
        break;
      end
      retries++;
      if (retries > 60) begin
        checkOutput("accept_timeout", 32'(retries), 32'd60);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic waitDrain(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_ack_valid", 32'(ack_valid), 32'd0);
    checkOutput("rst_ack_hit", 32'(ack_hit), 32'd0);
    checkOutput("rst_ack_miss", 32'(ack_miss), 32'd0);
    checkOutput("rst_ack_way", 32'(ack_way), 32'd0);
    checkOutput("rst_ack_state", 32'(ack_state), 32'd0);
    checkOutput("rst_ack_bank", 32'(ack_bank), 32'd0);
    checkOutput("rst_ack_req_type", 32'(ack_req_type), 32'd0);
    checkOutput("rst_req_retry", 32'(req_retry), 32'd1);
  endtask

  // Monitor: checks each new ack's latency, each stalled cycle's hold, and each consumed ack's contents.
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 0;
    end else if (ack_valid) begin
      cur = {17'd0, ack_hit, ack_miss, ack_way, ack_state, ack_bank, ack_req_type};
      if (prev_stall)
        checkOutput("stall_hold", cur, snap);
      else if (exp_q.size() == 0)
        checkOutput("unexpected_ack", 32'(exp_q.size()), 32'd1);
      else
        checkOutput("ack_latency", 32'(cycle - exp_q[0].acc_cycle),
                    32'(2 + stall_cnt - exp_q[0].acc_stalls));
      if (ack_retry) begin
        checkOutput("stall_req_retry", 32'(req_retry), 32'd1);
        snap = cur;
        prev_stall = 1;
        stall_cnt++;
      end else begin
        prev_stall = 0;
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("ack_hit", 32'(ack_hit), 32'(e.hit));
          checkOutput("ack_miss", 32'(ack_miss), 32'(e.miss));
          checkOutput("ack_way", 32'(ack_way), 32'(e.way));
          checkOutput("ack_state", 32'(ack_state), 32'(e.state));
          checkOutput("ack_bank", 32'(ack_bank), 32'(e.bank));
          checkOutput("ack_req_type", 32'(ack_req_type), 32'(e.rtype));
        end
      end
    end else begin
      if (prev_stall) checkOutput("stall_drop", 32'(ack_valid), 32'd1);
      prev_stall = 0;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d checks so far", num_checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_type = '0; req_set = '0;
    req_tag = '0; req_way = '0; req_state = '0; ack_retry = 1'b0;
    modelReset();
    #3;
    checkResetOutputs();
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    $display("[TB] lookup miss after reset");
    applyStimulus(0, 9'h004, 18'h01234, 2'd0, 3'd0, r);
    waitDrain(20);

    $display("[TB] write then back-to-back lookup");
    applyStimulus(1, 9'h005, 18'h00ABC, 2'd2, 3'd3, r);
    applyStimulus(0, 9'h005, 18'h00ABC, 2'd0, 3'd0, r);
    checkOutput("fwd_lookup_retries", 32'(r), 32'(FORWARD_P == 0 ? 1 : 0));
    waitDrain(20);

    $display("[TB] consumer stall with requests pending");
    ack_force = 1'b1;
    @(posedge clk); #1;
    fork
      begin
        applyStimulus(1, 9'h003, 18'h00077, 2'd1, 3'd5, r);
        applyStimulus(0, 9'h003, 18'h00077, 2'd0, 3'd0, r);
        applyStimulus(0, 9'h005, 18'h00ABC, 2'd0, 3'd0, r);
        applyStimulus(0, 9'h002, 18'h00099, 2'd0, 3'd0, r);
      end
      begin
        repeat (6) @(posedge clk);
        ack_force = 1'b0;
      end
    join
    waitDrain(40);

    $display("[TB] reset with requests in flight");
    applyStimulus(1, 9'h006, 18'h00055, 2'd1, 3'd2, r);
    applyStimulus(1, 9'h007, 18'h00066, 2'd0, 3'd4, r);
    reset = 1'b0;
    #1;
    checkResetOutputs();
    exp_q.delete();
    modelReset();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    $display("[TB] victim round-robin per bank");
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 9'(2 * i + 8), 18'(32'h3000 + i), 2'd0, 3'd0, r);
    applyStimulus(0, 9'h001, 18'h03FFF, 2'd0, 3'd0, r);
    waitDrain(30);
    applyStimulus(0, 9'h006, 18'h00055, 2'd0, 3'd0, r);
    applyStimulus(0, 9'h007, 18'h00066, 2'd0, 3'd0, r);
    applyStimulus(0, 9'h005, 18'h00ABC, 2'd0, 3'd0, r);
    waitDrain(30);

    $display("[TB] randomized traffic");
    rand_ack = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end else begin
        applyStimulus($urandom_range(0, 2) == 0,
                      ($urandom_range(0, 9) == 0) ? 9'($urandom) : 9'($urandom_range(0, 7)),
                      18'($urandom_range(0, 3)), 2'($urandom), 3'($urandom), r);
      end
    end
    rand_ack = 1'b0;
    ack_force = 1'b0;
    waitDrain(200);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/dc_tag_nbank.md
DC_TAG_NBANK -- requirements
Module: dc_tag_nbank

Interface
REQ-001 Parameter TAG_BITS, default 18, tag width compared on lookup.
REQ-002 Parameter SET_BITS, default 9, total set-index width (512 sets).
REQ-003 Parameter BANK_BITS, default 1, banks = 2^BANK_BITS; bank = req_set[BANK_BITS-1:0].
REQ-004 Parameter WAYS, default 4, power of 2; WB = log2(WAYS).
REQ-005 Parameter REQ_BITS, default 7, request-type tag width.
REQ-006 Parameter FORWARD, default 1, 1 = write-to-lookup bypass, 0 = stall instead.
REQ-007 Clocking is one clock; reset is asynchronous and active-low.
REQ-008 clk  in  1  sole clock, rising edge.
REQ-009 reset  in  1  asynchronous, active-low reset.
REQ-010 req_valid  in  1  request present.
REQ-011 req_retry  out  1  request not accepted this cycle.
REQ-012 req_write  in  1  1 = write tag/state, 0 = lookup.
REQ-013 req_type  in  REQ_BITS  opaque tag, returned on ack.
REQ-014 req_set  in  SET_BITS  set index.
REQ-015 req_tag  in  TAG_BITS  tag to write or search.
REQ-016 req_way  in  WB  target way (writes only).
REQ-017 req_state  in  3  coherence state to write; 0 = invalid.
REQ-018 ack_valid  out  1  response present.
REQ-019 ack_retry  in  1  consumer cannot take response.
REQ-020 ack_hit, ack_miss  out  1 each  exactly one set when ack_valid.
REQ-021 ack_way  out  WB  hit way, or victim way on miss.
REQ-022 ack_state  out  3  state of hit way; 0 on miss.
REQ-023 ack_bank  out  BANK_BITS  bank that served the request.
REQ-024 ack_req_type  out  REQ_BITS  echo of req_type.

Function
REQ-025 Storage per bank SHALL be 2^(SET_BITS-BANK_BITS) rows x WAYS entries of {tag, state}; row = req_set[SET_BITS-1:BANK_BITS].
REQ-026 Request accepted when req_valid=1 and req_retry=0.
REQ-027 Pipeline: S1 (array read/write) then S2 (compare, output register); ack_valid rises exactly 2 cycles after acceptance when not stalled.
REQ-028 Stall: while ack_valid=1 and ack_retry=1, S2 and S1 hold, req_retry=1, outputs stable.
REQ-029 Write: entry (bank,row,req_way) updated in S1 cycle; ack returns hit=1, way=req_way, state=req_state.
REQ-030 Lookup hit: any way with state!=0 and tag==req_tag; lowest-numbered matching way reported.
REQ-031 Lookup miss: ack_miss=1, ack_state=0, ack_way = that bank's round-robin victim pointer.
REQ-032 Victim pointer (one per bank, WB bits) increments mod WAYS when a miss ack is consumed (ack_valid=1, ack_retry=0); other banks unaffected.
REQ-033 FORWARD=1: a lookup in S1 whose bank/row matches the write in S2 SHALL see the written tag/state (no stale result).
REQ-034 FORWARD=0: a lookup to the same bank/row as the write in S1 SHALL be held off with req_retry=1 for exactly one cycle.
REQ-035 Back-to-back accepted requests SHALL sustain one per cycle when unstalled, in any bank mix.
REQ-036 Acks SHALL leave in acceptance order.

Reset
REQ-037 reset=0 asynchronously clears all state bits to 0 (invalid), all victim pointers to 0, S1/S2 valid to 0.
REQ-038 During reset: ack_valid=0, ack_hit=0, ack_miss=0, ack_way=0, ack_state=0, ack_bank=0, ack_req_type=0, req_retry=1.
REQ-039 Reset mid-operation discards in-flight requests; no ack is produced for them.
REQ-040 Tag bits need not be reset; they SHALL be unobservable while state=0.

Verification
REQ-041 After reset, lookup set=0x004 tag=0x1234 -> ack 2 cycles later, miss=1, way=0, state=0, bank=0.
REQ-042 Write set=0x005 way=2 tag=0x0ABC state=3, then lookup same -> hit=1, way=2, state=3, bank=1.
REQ-043 FORWARD=1: write then next-cycle lookup same set/tag -> hit=1 with one-per-cycle throughput; FORWARD=0 -> req_retry=1 for 1 cycle, then hit=1.
REQ-044 Four consumed misses to bank 0 -> ack_way 0,1,2,3; fifth -> 0; bank 1 pointer still 0.
REQ-045 Hold ack_retry=1 for 3 cycles with requests pending -> req_retry=1, ack outputs stable, no loss/reorder after release.
REQ-046 Assert reset=0 with two requests in flight -> ack_valid=0 immediately; after release, previously written entries report miss.
